// File: rtl/fetch_pkg.sv
// Shared types and sizing for the instruction fetch slice.
// Imported by the fetch interface, buffer and unit.
package fetch_pkg;

  localparam int INST_W   = 32;
  localparam int PC_W     = 32;
  localparam int FB_DEPTH = 2;
  localparam int FB_CNT_W = $clog2(FB_DEPTH + 1);

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } fb_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode instruction handshake.
// master = fetch side, slave = decode side.
interface fetch_unit_if;
  import fetch_pkg::*;

  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [PC_W-1:0]   inst_pc;

  modport master (
    output inst_valid,
    output inst,
    output inst_pc,
    input  inst_ready
  );

  modport slave (
    input  inst_valid,
    input  inst,
    input  inst_pc,
    output inst_ready
  );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry instruction FIFO between imem response and decode.
// Head reads as zero when empty.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                push,
  input  fb_entry_t           push_data,
  input  logic                pop,
  output fb_entry_t           head,
  output logic [FB_CNT_W-1:0] count
);

  fb_entry_t mem [FB_DEPTH];
  logic      wr_ptr;
  logic      rd_ptr;
  logic      do_pop;

  assign do_pop = pop && (count != '0);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + FB_CNT_W'(push)
                     - FB_CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst && !flush)
      mem[wr_ptr] <= push_data;
  end

  assign head = (count == '0) ? '0 : mem[rd_ptr];

  // The issue rule upstream must keep a slot free for every in-flight word.
  a_no_push_full: assert property (
    @(posedge clk) disable iff (rst || flush)
    push |-> (count != FB_CNT_W'(FB_DEPTH))
  );

endmodule

// File: rtl/fetch_unit.sv
// Program counter, single in-flight imem request and issue control.
// Responses land in fetch_buffer one cycle after the request edge.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_data,
  fetch_unit_if.master      dec
);

  localparam logic [PC_W-1:0] PC_MASK = ~PC_W'(3);

  logic [PC_W-1:0]     pc;
  logic [PC_W-1:0]     inflight_pc;
  logic                inflight;
  logic                issue;
  logic                pop;
  logic                push;
  logic [FB_CNT_W:0]   occ;
  logic [FB_CNT_W-1:0] count;
  fb_entry_t           head;
  fb_entry_t           wr_entry;

  assign imem_addr = pc >> 2;

  assign pop = dec.inst_valid && dec.inst_ready;

  // Occupancy after this edge; the new request needs a slot one edge later.
  assign occ = {1'b0, count}
             + (FB_CNT_W+1)'(inflight)
             - (FB_CNT_W+1)'(pop);

  assign issue = fetch_en && !redirect_valid && !rst
              && (occ < (FB_CNT_W+1)'(FB_DEPTH));

  assign push     = inflight && !redirect_valid;
  assign wr_entry = '{inst: imem_data, pc: inflight_pc};

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC & PC_MASK;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc & PC_MASK;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc          <= pc + PC_W'(4);
        inflight_pc <= pc;
      end
    end
  end

  fetch_buffer u_fb (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (wr_entry),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign dec.inst_valid = (count != '0) && !redirect_valid;
  assign dec.inst       = head.inst;
  assign dec.inst_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stalls, redirects, resets.
// A second instance exercises a non-zero RESET_PC and pc wrap.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid2;
  logic [31:0] redirect_pc2;
  logic [31:0] imem_addr2;
  logic [31:0] imem_data2;

  int checks = 0;
  int errors = 0;

  fetch_unit_if dif ();
  fetch_unit_if dif2 ();

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .dec            (dif)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid2),
    .redirect_pc    (redirect_pc2),
    .imem_addr      (imem_addr2),
    .imem_data      (imem_data2),
    .dec            (dif2)
  );

  function automatic logic [31:0] mw(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) begin
    imem_data  <= mw(imem_addr);
    imem_data2 <= mw(imem_addr2);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    fetch_en = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    dif.inst_ready = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    fetch_en = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    dif.inst_ready = 1'b0;
    tick;
    tick;
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (dif.inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b want 0", dif.inst_valid);
    end
    checks++;
    if (dif.inst !== 32'h0 || dif.inst_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_inst got %h/%h want 0/0", dif.inst, dif.inst_pc);
    end
    checks++;
    if (imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_addr got %h want 0", imem_addr);
    end
    checks++;
    if (imem_addr2 !== 32'h3FFF_FFFE) begin
      errors++;
      $display("FAIL reset_addr2 got %h want 3ffffffe", imem_addr2);
    end
    checks++;
    if (dif2.inst_valid !== 1'b0 || dif2.inst_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_dut2 got %b/%h want 0/0", dif2.inst_valid, dif2.inst_pc);
    end
  endtask

  task automatic test_stream;
    do_reset;
    fetch_en = 1'b1;
    #1;
    checks++;
    if (imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL stream_addr0 got %h want 0", imem_addr);
    end
    for (int i = 1; i <= 6; i++) begin
      tick;
      checks++;
      if (imem_addr !== 32'(i)) begin
        errors++;
        $display("FAIL stream_addr got %h want %h", imem_addr, 32'(i));
      end
      checks++;
      if (i < 2) begin
        if (dif.inst_valid !== 1'b0) begin
          errors++;
          $display("FAIL stream_early got %b want 0", dif.inst_valid);
        end
      end else if (dif.inst_valid !== 1'b1 || dif.inst_pc !== 32'((i-2)*4)
                   || dif.inst !== mw(32'(i-2))) begin
        errors++;
        $display("FAIL stream_inst got %b/%h/%h want 1/%h/%h", dif.inst_valid,
                 dif.inst_pc, dif.inst, 32'((i-2)*4), mw(32'(i-2)));
      end
    end
  endtask

  task automatic test_wrap;
    logic [31:0] exp_pc;
    do_reset;
    fetch_en = 1'b1;
    tick;
    tick;
    for (int k = 0; k < 4; k++) begin
      exp_pc = 32'hFFFF_FFF8 + 32'(k*4);
      checks++;
      if (dif2.inst_valid !== 1'b1 || dif2.inst_pc !== exp_pc
          || dif2.inst !== mw(exp_pc >> 2)) begin
        errors++;
        $display("FAIL wrap_inst got %b/%h/%h want 1/%h/%h", dif2.inst_valid,
                 dif2.inst_pc, dif2.inst, exp_pc, mw(exp_pc >> 2));
      end
      tick;
    end
  endtask

  task automatic test_stall;
    do_reset;
    fetch_en = 1'b1;
    repeat (4) tick;
    dif.inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if (dif.inst_valid !== 1'b1 || dif.inst_pc !== 32'h8
          || dif.inst !== mw(32'h2) || imem_addr !== 32'h4) begin
        errors++;
        $display("FAIL stall_hold got %b/%h/%h/%h want 1/8/%h/4", dif.inst_valid,
                 dif.inst_pc, dif.inst, imem_addr, mw(32'h2));
      end
    end
    dif.inst_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      checks++;
      if (dif.inst_valid !== 1'b1 || dif.inst_pc !== 32'(12 + 4*k)
          || dif.inst !== mw(32'(3 + k))) begin
        errors++;
        $display("FAIL stall_resume got %b/%h/%h want 1/%h/%h", dif.inst_valid,
                 dif.inst_pc, dif.inst, 32'(12 + 4*k), mw(32'(3 + k)));
      end
    end
  endtask

  task automatic test_redirect_full;
    do_reset;
    fetch_en = 1'b1;
    repeat (4) tick;
    dif.inst_ready = 1'b0;
    tick;
    tick;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    dif.inst_ready = 1'b1;
    #1;
    checks++;
    if (dif.inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_cycle_valid got %b want 0", dif.inst_valid);
    end
    tick;
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (dif.inst_valid !== 1'b0 || imem_addr !== 32'h10) begin
      errors++;
      $display("FAIL redir_flush got %b/%h want 0/10", dif.inst_valid, imem_addr);
    end
    tick;
    checks++;
    if (dif.inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_gap got %b want 0", dif.inst_valid);
    end
    tick;
    checks++;
    if (dif.inst_valid !== 1'b1 || dif.inst_pc !== 32'h40
        || dif.inst !== mw(32'h10)) begin
      errors++;
      $display("FAIL redir_target got %b/%h/%h want 1/40/%h", dif.inst_valid,
               dif.inst_pc, dif.inst, mw(32'h10));
    end
    tick;
    checks++;
    if (dif.inst_valid !== 1'b1 || dif.inst_pc !== 32'h44) begin
      errors++;
      $display("FAIL redir_next got %b/%h want 1/44", dif.inst_valid, dif.inst_pc);
    end
  endtask

  task automatic test_redirect_squash;
    do_reset;
    fetch_en = 1'b1;
    repeat (4) tick;
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    tick;
    redirect_valid = 1'b0;
    tick;
    checks++;
    if (dif.inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL squash_gap got %b/%h want 0", dif.inst_valid, dif.inst_pc);
    end
    tick;
    checks++;
    if (dif.inst_valid !== 1'b1 || dif.inst_pc !== 32'h100
        || dif.inst !== mw(32'h40)) begin
      errors++;
      $display("FAIL squash_target got %b/%h/%h want 1/100/%h", dif.inst_valid,
               dif.inst_pc, dif.inst, mw(32'h40));
    end
    tick;
    checks++;
    if (dif.inst_pc !== 32'h104) begin
      errors++;
      $display("FAIL squash_next got %h want 104", dif.inst_pc);
    end
  endtask

  task automatic test_fetch_en;
    do_reset;
    fetch_en = 1'b1;
    repeat (4) tick;
    fetch_en = 1'b0;
    tick;
    checks++;
    if (dif.inst_valid !== 1'b1 || dif.inst_pc !== 32'hC || imem_addr !== 32'h4) begin
      errors++;
      $display("FAIL fen_drain got %b/%h/%h want 1/c/4", dif.inst_valid,
               dif.inst_pc, imem_addr);
    end
    tick;
    checks++;
    if (dif.inst_valid !== 1'b0 || dif.inst !== 32'h0 || dif.inst_pc !== 32'h0) begin
      errors++;
      $display("FAIL fen_empty got %b/%h/%h want 0/0/0", dif.inst_valid,
               dif.inst, dif.inst_pc);
    end
    tick;
    checks++;
    if (dif.inst_valid !== 1'b0 || imem_addr !== 32'h4) begin
      errors++;
      $display("FAIL fen_hold got %b/%h want 0/4", dif.inst_valid, imem_addr);
    end
    fetch_en = 1'b1;
    tick;
    tick;
    checks++;
    if (dif.inst_valid !== 1'b1 || dif.inst_pc !== 32'h10) begin
      errors++;
      $display("FAIL fen_resume got %b/%h want 1/10", dif.inst_valid, dif.inst_pc);
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    fetch_en = 1'b1;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    checks++;
    if (dif.inst_valid !== 1'b0 || dif.inst !== 32'h0 || dif.inst_pc !== 32'h0) begin
      errors++;
      $display("FAIL rmid_clear got %b/%h/%h want 0/0/0", dif.inst_valid,
               dif.inst, dif.inst_pc);
    end
    tick;
    checks++;
    if (dif.inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmid_leak got %b/%h want 0", dif.inst_valid, dif.inst_pc);
    end
    tick;
    checks++;
    if (dif.inst_valid !== 1'b1 || dif.inst_pc !== 32'h0 || dif.inst !== mw(32'h0)) begin
      errors++;
      $display("FAIL rmid_first got %b/%h/%h want 1/0/%h", dif.inst_valid,
               dif.inst_pc, dif.inst, mw(32'h0));
    end
  endtask

  task automatic test_reset_wins;
    do_reset;
    fetch_en = 1'b1;
    repeat (3) tick;
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h43;
    tick;
    checks++;
    if (imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rwin_pc got %h want 0", imem_addr);
    end
    rst = 1'b0;
    tick;
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (imem_addr !== 32'h10) begin
      errors++;
      $display("FAIL rwin_redir got %h want 10", imem_addr);
    end
    tick;
    tick;
    checks++;
    if (dif.inst_valid !== 1'b1 || dif.inst_pc !== 32'h40
        || dif.inst !== mw(32'h10)) begin
      errors++;
      $display("FAIL rwin_target got %b/%h/%h want 1/40/%h", dif.inst_valid,
               dif.inst_pc, dif.inst, mw(32'h10));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    fetch_en = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    redirect_valid2 = 1'b0;
    redirect_pc2 = '0;
    dif.inst_ready = 1'b0;
    dif2.inst_ready = 1'b1;
    test_reset;
    test_stream;
    test_wrap;
    test_stall;
    test_redirect_full;
    test_redirect_squash;
    test_fetch_en;
    test_reset_mid;
    test_reset_wins;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
